// File: rtl/mem_access.sv
// mem_access: RV32I memory stage (load/store over req/ready/rvalid, misalignment traps).
// Define MEM_TIMEOUT_EN to abort transactions that stall longer than TIMEOUT_CYCLES.
module mem_access #(
  parameter int XLEN = 32,
  parameter int EXW = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [4:0]      opcode_in,
  input  logic [2:0]      funct_in,
  input  logic            nop_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            exc_valid_in,
  input  logic [EXW-1:0]  exc_in,
  input  logic            valid_in,
  input  logic            halt_in,
  input  logic            flush,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic [4:0]      opcode_out,
  output logic [2:0]      funct_out,
  output logic            nop_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_addr_out,
  output logic            exc_valid_out,
  output logic [EXW-1:0]  exc_out,
  output logic            valid_out,
  output logic            halt_out
);
  typedef enum logic [1:0] {IDLE, WAIT_RSP, DRAIN} state_t;
  state_t state, state_nx;
  logic is_load, is_store, act, mis, issue, done, adv, to, ign, ign_nx;
  logic [1:0] a;
  logic [XLEN-1:0] sh, fmt;
  assign a = alu_result_in[1:0];
  assign is_load = opcode_in == 5'b00000;
  assign is_store = opcode_in == 5'b01000;
  assign act = valid_in & ~nop_in & ~flush & (is_load | is_store);
  assign mis = funct_in[1] ? a != 2'b00 : funct_in[0] & a[0];
  assign issue = state == IDLE & act & ~exc_valid_in & ~mis;
  assign done = state == WAIT_RSP & dmem_rvalid & ~ign & ~flush;
  assign dmem_req = issue;
  assign dmem_we = issue & is_store;
  assign dmem_addr = {alu_result_in[XLEN-1:2], 2'b00};
  assign dmem_wdata = funct_in[1] ? store_data_in :
                      funct_in[0] ? {(XLEN/16){store_data_in[15:0]}} : {(XLEN/8){store_data_in[7:0]}};
  assign dmem_be = funct_in[1] ? 4'b1111 : (funct_in[0] ? 4'b0011 : 4'b0001) << a;
  assign sh = dmem_rdata >> {a, 3'b000};
  assign fmt = funct_in[1] ? dmem_rdata :
               funct_in[0] ? {{(XLEN-16){~funct_in[2] & sh[15]}}, sh[15:0]} :
                             {{(XLEN-8){~funct_in[2] & sh[7]}}, sh[7:0]};
  assign stall_out = ~adv;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic waiting;
  assign waiting = issue & ~dmem_ready | state != IDLE & ~(dmem_rvalid & ~ign);
  assign to = waiting & cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) cnt <= reset | ~waiting | to ? 8'd0 : cnt + 8'd1;
`else
  logic unused_to;
  assign unused_to = |TIMEOUT_CYCLES;
  assign to = 1'b0;
`endif
  // ign marks a response still in flight from an aborted load
  always_comb begin
    state_nx = state;
    ign_nx = ign;
    adv = 1'b0;
    if (state == IDLE) begin
      adv = ~issue | dmem_ready & is_store | to;
      state_nx = issue & dmem_ready & is_load ? WAIT_RSP : IDLE;
    end else begin
      adv = done | state == WAIT_RSP & to;
      state_nx = dmem_rvalid & ~ign | to ? IDLE : flush | state == DRAIN ? DRAIN : WAIT_RSP;
      ign_nx = to | ign & ~dmem_rvalid;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ign <= 1'b0;
      valid_out <= 1'b0;
      pc_out <= '0;
      instr_out <= '0;
      opcode_out <= '0;
      funct_out <= '0;
      nop_out <= 1'b0;
      result_out <= '0;
      rd_addr_out <= '0;
      exc_valid_out <= 1'b0;
      exc_out <= '0;
      halt_out <= 1'b0;
    end else begin
      state <= state_nx;
      ign <= ign_nx;
      valid_out <= adv & valid_in & ~flush;
      if (adv) begin
        pc_out <= pc_in;
        instr_out <= instr_in;
        opcode_out <= opcode_in;
        funct_out <= funct_in;
        nop_out <= nop_in;
        result_out <= done ? fmt : alu_result_in;
        rd_addr_out <= rd_addr_in;
        halt_out <= halt_in;
        exc_valid_out <= exc_valid_in | act & mis | to;
        exc_out <= exc_valid_in ? exc_in : act & mis ? EXW'(is_load ? 4 : 6) :
                   to ? EXW'(is_load ? 5 : 7) : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (TIMEOUT_CYCLES=4).
module tb_mem_access;
  logic clk = 1'b0, reset;
  logic [31:0] pc_in, instr_in, alu_result_in, store_data_in, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_out, instr_out, result_out;
  logic [4:0] opcode_in, rd_addr_in, opcode_out, rd_addr_out;
  logic [2:0] funct_in, funct_out;
  logic [3:0] exc_in, exc_out, dmem_be;
  logic nop_in, exc_valid_in, valid_in, halt_in, flush, stall_out, dmem_req, dmem_we;
  logic dmem_ready, dmem_rvalid, nop_out, exc_valid_out, valid_out, halt_out;
  int errors = 0, checks = 0;

  mem_access #(.XLEN(32), .EXW(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in), .opcode_in(opcode_in),
    .funct_in(funct_in), .nop_in(nop_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .rd_addr_in(rd_addr_in), .exc_valid_in(exc_valid_in),
    .exc_in(exc_in), .valid_in(valid_in), .halt_in(halt_in), .flush(flush),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .pc_out(pc_out),
    .instr_out(instr_out), .opcode_out(opcode_out), .funct_out(funct_out), .nop_out(nop_out),
    .result_out(result_out), .rd_addr_out(rd_addr_out), .exc_valid_out(exc_valid_out),
    .exc_out(exc_out), .valid_out(valid_out), .halt_out(halt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 0; opcode_in = 5'b00100; funct_in = 0; nop_in = 0; alu_result_in = 0;
    store_data_in = 0; rd_addr_in = 0; exc_valid_in = 0; exc_in = 0; halt_in = 0; flush = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0; pc_in = 0; instr_in = 0;
  endtask

  task automatic mem_op(input logic [4:0] op, input logic [2:0] f, input logic [31:0] addr);
    valid_in = 1; opcode_in = op; funct_in = f; alu_result_in = addr;
  endtask

  initial begin
    idle_in();
    reset = 1;
    tick(); tick();
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_result", result_out, 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_excv", 32'(exc_valid_out), 0);
    reset = 0;
    // ADD pass-through
    mem_op(5'b01100, 3'b000, 32'h1234); rd_addr_in = 5; pc_in = 32'h40; #1;
    chk("add_req", 32'(dmem_req), 0);
    chk("add_stall", 32'(stall_out), 0);
    tick();
    chk("add_valid", 32'(valid_out), 1);
    chk("add_result", result_out, 32'h1234);
    chk("add_rd", 32'(rd_addr_out), 5);
    chk("add_pc", pc_out, 32'h40);
    idle_in();
    // LB at 0x103, ready late, rvalid 3 cycles after acceptance
    mem_op(5'b00000, 3'b000, 32'h103); rd_addr_in = 7; #1;
    chk("lb_req0", 32'(dmem_req), 1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", 32'(dmem_we), 0);
    chk("lb_stall0", 32'(stall_out), 1);
    tick();
    chk("lb_req1", 32'(dmem_req), 1);
    chk("lb_stall1", 32'(stall_out), 1);
    chk("lb_valid1", 32'(valid_out), 0);
    tick();
    dmem_ready = 1; #1;
    chk("lb_stall_rdy", 32'(stall_out), 1);
    tick();
    dmem_ready = 0; #1;
    chk("lb_wait_req", 32'(dmem_req), 0);
    chk("lb_wait_stall", 32'(stall_out), 1);
    tick();
    chk("lb_wait_stall2", 32'(stall_out), 1);
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h8000_0000; #1;
    chk("lb_rv_stall", 32'(stall_out), 0);
    tick();
    dmem_rvalid = 0;
    chk("lb_valid", 32'(valid_out), 1);
    chk("lb_result", result_out, 32'hFFFF_FF80);
    chk("lb_rd", 32'(rd_addr_out), 7);
    // back-to-back LBU at same address, immediate ready
    funct_in = 3'b100; dmem_ready = 1; #1;
    chk("lbu_req", 32'(dmem_req), 1);
    tick();
    dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'h8000_0000;
    tick();
    dmem_rvalid = 0;
    chk("lbu_result", result_out, 32'h0000_0080);
    // LH upper half, sign extension
    funct_in = 3'b001; alu_result_in = 32'h102; dmem_ready = 1;
    tick();
    dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'h8001_1234;
    tick();
    dmem_rvalid = 0;
    chk("lh_result", result_out, 32'hFFFF_8001);
    idle_in();
    // SH at 0x102
    mem_op(5'b01000, 3'b001, 32'h102); store_data_in = 32'h0000_ABCD; dmem_ready = 1; #1;
    chk("sh_addr", dmem_addr, 32'h100);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem_we), 1);
    chk("sh_stall", 32'(stall_out), 0);
    tick();
    chk("sh_valid", 32'(valid_out), 1);
    chk("sh_excv", 32'(exc_valid_out), 0);
    idle_in();
    // SB lane 1
    mem_op(5'b01000, 3'b000, 32'h201); store_data_in = 32'h1234_56A5; dmem_ready = 1; #1;
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    tick();
    idle_in();
    // misaligned LW
    mem_op(5'b00000, 3'b010, 32'h101); #1;
    chk("mlw_req", 32'(dmem_req), 0);
    chk("mlw_stall", 32'(stall_out), 0);
    tick();
    chk("mlw_valid", 32'(valid_out), 1);
    chk("mlw_excv", 32'(exc_valid_out), 1);
    chk("mlw_exc", 32'(exc_out), 4);
    chk("mlw_result", result_out, 32'h101);
    // misaligned SW
    mem_op(5'b01000, 3'b010, 32'h102); #1;
    chk("msw_req", 32'(dmem_req), 0);
    tick();
    chk("msw_exc", 32'(exc_out), 6);
    // upstream exception on an aligned load
    mem_op(5'b00000, 3'b010, 32'h100); exc_valid_in = 1; exc_in = 2; #1;
    chk("uexc_req", 32'(dmem_req), 0);
    tick();
    chk("uexc_excv", 32'(exc_valid_out), 1);
    chk("uexc_exc", 32'(exc_out), 2);
    idle_in();
    // flush during WAIT_RSP drains the response
    mem_op(5'b00000, 3'b010, 32'h300); dmem_ready = 1;
    tick();
    dmem_ready = 0; flush = 1; #1;
    chk("fl_stall", 32'(stall_out), 1);
    tick();
    flush = 0; valid_in = 0;
    chk("fl_valid", 32'(valid_out), 0);
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h5555_5555; #1;
    chk("drain_stall", 32'(stall_out), 1);
    tick();
    dmem_rvalid = 0;
    chk("drain_valid", 32'(valid_out), 0);
    mem_op(5'b00000, 3'b010, 32'h200); dmem_ready = 1; #1;
    chk("post_req", 32'(dmem_req), 1);
    chk("post_addr", dmem_addr, 32'h200);
    tick();
    dmem_ready = 0; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 0;
    chk("post_valid", 32'(valid_out), 1);
    chk("post_result", result_out, 32'hDEAD_BEEF);
    idle_in();
    // reset mid-transaction, late rvalid ignored
    mem_op(5'b00000, 3'b010, 32'h400); dmem_ready = 1;
    tick();
    idle_in(); reset = 1;
    tick();
    reset = 0; #1;
    chk("rmid_stall", 32'(stall_out), 0);
    chk("rmid_valid", 32'(valid_out), 0);
    dmem_rvalid = 1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_rvalid = 0;
    chk("rmid_late", 32'(valid_out), 0);
    chk("rmid_result", result_out, 0);
`ifdef MEM_TIMEOUT_EN
    // SW never accepted: abort on 4th waiting cycle
    mem_op(5'b01000, 3'b010, 32'h104); #1;
    chk("to_stall0", 32'(stall_out), 1);
    tick();
    chk("to_stall1", 32'(stall_out), 1);
    tick();
    chk("to_stall2", 32'(stall_out), 1);
    tick();
    chk("to_stall3", 32'(stall_out), 0);
    tick();
    chk("to_valid", 32'(valid_out), 1);
    chk("to_excv", 32'(exc_valid_out), 1);
    chk("to_exc", 32'(exc_out), 7);
    idle_in();
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
